// File: rtl/rv32i_core.sv
// rtl/rv32i_core.sv - multi-cycle RV32I core, 5 clocks/instruction; optional macro RV32I_HALT_ON_ILLEGAL_EN

// 32-entry register file; x0 is hardwired to zero on read and never written
module rv32i_regfile #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int REG_S  = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [REG_W-1:0]  rs1_addr,
  input  logic [REG_W-1:0]  rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  input  logic              we,
  input  logic [REG_W-1:0]  wa,
  input  logic [DATA_W-1:0] wd
);
  logic [DATA_W-1:0] rf [0:REG_S-1];

  // reset clears every entry; writes to x0 are dropped
  always_ff @(posedge clk) begin
    if (n_rst) begin
      for (int i = 0; i < REG_S; i++) rf[i] <= '0;
    end else if (we && wa != '0) begin
      rf[wa] <= wd;
    end
  end

  assign rs1_data = (rs1_addr == '0) ? '0 : rf[rs1_addr];
  assign rs2_data = (rs2_addr == '0) ? '0 : rf[rs2_addr];
endmodule

module rv32i_core #(
  parameter int MEMORY_S = 256,
  parameter int PC_W     = 8,
  parameter int DATA_W   = 32,
  parameter int REG_W    = 5,
  parameter int REG_S    = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [DATA_W-1:0] instruction,
  output logic [PC_W-1:0]   pc,
  input  logic [DATA_W-1:0] d_in,
  output logic              wr_en,
  output logic [1:0]        mode,
  output logic [PC_W-1:0]   wr_addr,
  output logic [PC_W-1:0]   rd_addr,
  output logic [DATA_W-1:0] d_out
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  // keeps the new pc word aligned and inside the address space in one AND
  localparam logic [DATA_W-1:0] PC_MASK = DATA_W'(MEMORY_S - 4);

  state_t state, state_next;

  logic [6:0]        ir_op;
  logic [REG_W-1:0]  ir_rd;
  logic [2:0]        ir_f3;
  logic              ir_f7b5;
  logic [DATA_W-1:0] rs1_q, rs2_q, imm_q, result_q;
  logic [PC_W-1:0]   pc_next_q;

  logic [DATA_W-1:0] rs1_data, rs2_data, imm, alu_b, alu, exec_res, target, pc_ext, load_val, wb_data;
  logic [PC_W-1:0]   ea;
  logic              taken, writes_rd;

  rv32i_regfile #(.DATA_W(DATA_W), .REG_W(REG_W), .REG_S(REG_S)) rfile (
    .clk(clk), .n_rst(n_rst),
    .rs1_addr(instruction[19:15]), .rs2_addr(instruction[24:20]),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .we(state == WB && writes_rd), .wa(ir_rd), .wd(wb_data)
  );

`ifdef RV32I_HALT_ON_ILLEGAL_EN
  logic legal;
  // opcode whitelist; SYSTEM (ECALL/EBREAK) and unknown opcodes halt the core
  always_comb begin
    case (instruction[6:0])
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE,
      OP_IMM, OP_REG, 7'b0001111: legal = 1'b1;
      default:                    legal = 1'b0;
    endcase
  end
`endif

  // sequencer state register
  always_ff @(posedge clk) begin
    if (n_rst) state <= FETCH;
    else       state <= state_next;
  end

  // fixed cyclic sequence; HALT is left only through reset
  always_comb begin
    state_next = state;
    case (state)
      FETCH:  state_next = DECODE;
`ifdef RV32I_HALT_ON_ILLEGAL_EN
      DECODE: state_next = legal ? EXEC : HALT;
`else
      DECODE: state_next = EXEC;
`endif
      EXEC:   state_next = MEM;
      MEM:    state_next = WB;
      WB:     state_next = FETCH;
      HALT:   state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  // immediate built straight from the instruction bus during DECODE
  always_comb begin
    case (instruction[6:0])
      OP_LUI, OP_AUIPC: imm = {instruction[31:12], 12'b0};
      OP_JAL:    imm = {{12{instruction[31]}}, instruction[19:12], instruction[20], instruction[30:21], 1'b0};
      OP_BRANCH: imm = {{20{instruction[31]}}, instruction[7], instruction[30:25], instruction[11:8], 1'b0};
      OP_STORE:  imm = {{21{instruction[31]}}, instruction[30:25], instruction[11:7]};
      default:   imm = {{21{instruction[31]}}, instruction[30:20]};
    endcase
  end

  // ALU, branch decision, result and next-pc selection used in EXEC
  always_comb begin
    pc_ext = {{(DATA_W-PC_W){1'b0}}, pc};
    alu_b  = (ir_op == OP_REG) ? rs2_q : imm_q;
    case (ir_f3)
      3'b000:  alu = (ir_op == OP_REG && ir_f7b5) ? rs1_q - alu_b : rs1_q + alu_b;
      3'b001:  alu = rs1_q << alu_b[4:0];
      3'b010:  alu = {{(DATA_W-1){1'b0}}, $signed(rs1_q) < $signed(alu_b)};
      3'b011:  alu = {{(DATA_W-1){1'b0}}, rs1_q < alu_b};
      3'b100:  alu = rs1_q ^ alu_b;
      3'b101:  alu = ir_f7b5 ? DATA_W'($signed(rs1_q) >>> alu_b[4:0]) : rs1_q >> alu_b[4:0];
      3'b110:  alu = rs1_q | alu_b;
      default: alu = rs1_q & alu_b;
    endcase
    case (ir_f3)
      3'b000:  taken = (rs1_q == rs2_q);
      3'b001:  taken = (rs1_q != rs2_q);
      3'b100:  taken = ($signed(rs1_q) < $signed(rs2_q));
      3'b101:  taken = ($signed(rs1_q) >= $signed(rs2_q));
      3'b110:  taken = (rs1_q < rs2_q);
      3'b111:  taken = (rs1_q >= rs2_q);
      default: taken = 1'b0;
    endcase
    exec_res = alu;
    target   = pc_ext + 4;
    case (ir_op)
      OP_LUI:    exec_res = imm_q;
      OP_AUIPC:  exec_res = pc_ext + imm_q;
      OP_JAL:    begin exec_res = pc_ext + 4; target = pc_ext + imm_q; end
      OP_JALR:   begin exec_res = pc_ext + 4; target = rs1_q + imm_q; end
      OP_BRANCH: if (taken) target = pc_ext + imm_q;
      default:   ;
    endcase
    ea = PC_W'(rs1_q + imm_q);
  end

  // load extension and register write-back selection
  always_comb begin
    case (ir_f3)
      3'b000:  load_val = {{(DATA_W-8){d_in[7]}}, d_in[7:0]};
      3'b001:  load_val = {{(DATA_W-16){d_in[15]}}, d_in[15:0]};
      3'b100:  load_val = {{(DATA_W-8){1'b0}}, d_in[7:0]};
      3'b101:  load_val = {{(DATA_W-16){1'b0}}, d_in[15:0]};
      default: load_val = d_in;
    endcase
    wb_data = (ir_op == OP_LOAD) ? load_val : result_q;
    case (ir_op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_REG, OP_LOAD: writes_rd = 1'b1;
      default: writes_rd = 1'b0;
    endcase
  end

  // datapath registers and memory-side outputs; wr_en is a single MEM-cycle pulse
  always_ff @(posedge clk) begin
    if (n_rst) begin
      pc        <= '0;
      wr_en     <= 1'b0;
      mode      <= 2'b10;
      wr_addr   <= '0;
      rd_addr   <= '0;
      d_out     <= '0;
      ir_op     <= '0;
      ir_rd     <= '0;
      ir_f3     <= '0;
      ir_f7b5   <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      result_q  <= '0;
      pc_next_q <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        DECODE: begin
          ir_op   <= instruction[6:0];
          ir_rd   <= instruction[11:7];
          ir_f3   <= instruction[14:12];
          ir_f7b5 <= instruction[30];
          rs1_q   <= rs1_data;
          rs2_q   <= rs2_data;
          imm_q   <= imm;
        end
        EXEC: begin
          result_q  <= exec_res;
          pc_next_q <= PC_W'(target & PC_MASK);
          if (ir_op == OP_STORE) begin
            wr_en   <= 1'b1;
            wr_addr <= ea;
            d_out   <= rs2_q;
            mode    <= ir_f3[1:0];
          end
          if (ir_op == OP_LOAD) begin
            rd_addr <= ea;
            mode    <= ir_f3[1:0];
          end
        end
        WB:      pc <= pc_next_q;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rv32i_core.sv
// tb/tb_rv32i_core.sv - self-checking bench for rv32i_core with store scoreboard
module tb_rv32i_core;
  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic [31:0] instruction;
  logic [7:0]  pc;
  logic [31:0] d_in;
  logic        wr_en;
  logic [1:0]  mode;
  logic [7:0]  wr_addr, rd_addr;
  logic [31:0] d_out;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct packed {logic [1:0] mode; logic [7:0] addr; logic [31:0] data;} st_t;
  st_t exp_st[$];

  logic [31:0] imem [0:63];
  logic [7:0]  dmem [0:255];
  logic        wr_en_prev = 1'b0;
  logic [31:0] exp_rf [1:11];
  int          br_f3 [4] = '{0, 1, 5, 6};
  logic [7:0]  br_pc [4] = '{8'h2C, 8'h24, 8'h2C, 8'h24};

  rv32i_core dut (
    .clk(clk), .n_rst(n_rst), .instruction(instruction), .pc(pc), .d_in(d_in),
    .wr_en(wr_en), .mode(mode), .wr_addr(wr_addr), .rd_addr(rd_addr), .d_out(d_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
    logic [31:0] i;
    i = imm;
    return {i[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
  endfunction
  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
    logic [31:0] i;
    i = imm;
    return {i[11:5], 5'(rs2), 5'(rs1), 3'(f3), i[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    logic [31:0] i;
    i = imm;
    return {i[12], i[10:5], 5'(rs2), 5'(rs1), 3'(f3), i[4:1], i[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(int imm20, int rd, int op);
    logic [31:0] i;
    i = imm20;
    return {i[19:0], 5'(rd), 7'(op)};
  endfunction
  function automatic logic [31:0] enc_j(int imm, int rd);
    logic [31:0] i;
    i = imm;
    return {i[20], i[10:1], i[11], i[19:12], 5'(rd), 7'b1101111};
  endfunction

  function automatic logic [31:0] dm_read(input logic [7:0] a, input logic [1:0] m);
    logic [7:0] a1, a2, a3;
    a1 = a + 8'd1; a2 = a + 8'd2; a3 = a + 8'd3;
    case (m)
      2'b00:   return {24'h0, dmem[a]};
      2'b01:   return {16'h0, dmem[a1], dmem[a]};
      default: return {dmem[a3], dmem[a2], dmem[a1], dmem[a]};
    endcase
  endfunction

  function automatic logic [31:0] rf(int i);
    return dut.rfile.rf[i];
  endfunction

  // instruction memory with one-cycle registered read
  always @(posedge clk) instruction <= imem[pc[7:2]];

  // byte-addressed data memory, registered read, right-justified data
  always @(posedge clk) begin
    if (wr_en) begin
      dmem[wr_addr] <= d_out[7:0];
      if (mode != 2'b00) dmem[8'(wr_addr + 8'd1)] <= d_out[15:8];
      if (mode == 2'b10) begin
        dmem[8'(wr_addr + 8'd2)] <= d_out[23:16];
        dmem[8'(wr_addr + 8'd3)] <= d_out[31:24];
      end
    end
    d_in <= dm_read(rd_addr, mode);
  end

  // store monitor: each strobe pops the oldest expected store
  always @(negedge clk) begin
    if (wr_en) begin
      check("wr_en_1cyc", {31'b0, wr_en_prev}, 32'd0);
      check("st_pending", {31'b0, exp_st.size() != 0}, 32'd1);
      if (exp_st.size() != 0) begin
        st_t e;
        e = exp_st.pop_front();
        check("st_addr", {24'b0, wr_addr}, {24'b0, e.addr});
        check("st_data", d_out, e.data);
        check("st_mode", {30'b0, mode}, {30'b0, e.mode});
      end
    end
    wr_en_prev = wr_en;
  end

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
  endtask

  task automatic do_reset();
    n_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b0;
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] acc;
    clear_imem();
    do_reset();
    check("rst_pc", {24'b0, pc}, 32'd0);
    check("rst_wr_en", {31'b0, wr_en}, 32'd0);
    check("rst_mode", {30'b0, mode}, 32'd2);
    check("rst_wr_addr", {24'b0, wr_addr}, 32'd0);
    check("rst_rd_addr", {24'b0, rd_addr}, 32'd0);
    check("rst_d_out", d_out, 32'd0);
    check("rst_state", {29'b0, dut.state}, 32'd0);

    clear_imem();
    imem[0] = enc_u(32'hDEADC, 1, 7'h37);
    imem[1] = enc_i(-32'h111, 1, 0, 1, 7'h13);
    do_reset();
    step(10);
    check("lui_addi_x1", rf(1), 32'hDEADBEEF);
    check("lui_addi_pc", {24'b0, pc}, 32'h08);

    clear_imem();
    imem[0] = enc_i(32'h80, 0, 0, 2, 7'h13);
    imem[1] = enc_s(32'h10, 2, 0, 2);
    imem[2] = enc_i(32'h10, 0, 0, 3, 7'h03);
    imem[3] = enc_i(32'h10, 0, 4, 4, 7'h03);
    imem[4] = enc_i(-2, 0, 0, 5, 7'h13);
    imem[5] = enc_s(32'h12, 5, 0, 1);
    imem[6] = enc_i(32'h12, 0, 1, 6, 7'h03);
    imem[7] = enc_i(32'h12, 0, 5, 7, 7'h03);
    exp_st.push_back('{mode: 2'b10, addr: 8'h10, data: 32'h80});
    exp_st.push_back('{mode: 2'b01, addr: 8'h12, data: 32'hFFFF_FFFE});
    do_reset();
    step(40);
    check("lb_x3", rf(3), 32'hFFFF_FF80);
    check("lbu_x4", rf(4), 32'h80);
    check("lh_x6", rf(6), 32'hFFFF_FFFE);
    check("lhu_x7", rf(7), 32'h0000_FFFE);
    check("ld_rd_addr", {24'b0, rd_addr}, 32'h12);
    check("ld_mode", {30'b0, mode}, 32'd1);
    check("ld_pc", {24'b0, pc}, 32'h20);
    check("sb_empty", exp_st.size(), 32'd0);

    for (int v = 0; v < 4; v++) begin
      clear_imem();
      imem[0]  = enc_i(7, 0, 0, 4, 7'h13);
      imem[1]  = enc_i(7, 0, 0, 5, 7'h13);
      imem[2]  = enc_j(32'h18, 0);
      imem[8]  = enc_b(12, 5, 4, br_f3[v]);
      do_reset();
      step(20);
      check($sformatf("br_f3_%0d_pc", br_f3[v]), {24'b0, pc}, {24'b0, br_pc[v]});
    end

    clear_imem();
    imem[0]  = enc_j(32'hFC, 0);
    imem[63] = enc_j(8, 1);
    imem[1]  = enc_i(5, 0, 0, 0, 7'h13);
    do_reset();
    step(10);
    check("jal_wrap_pc", {24'b0, pc}, 32'h04);
    check("jal_link_x1", rf(1), 32'h100);
    step(5);
    check("x0_stays_0", rf(0), 32'd0);
    check("x0_pc", {24'b0, pc}, 32'h08);

    clear_imem();
    imem[0]  = enc_i(-16, 0, 0, 1, 7'h13);
    imem[1]  = enc_i(3, 0, 0, 2, 7'h13);
    imem[2]  = enc_r(7'h20, 2, 1, 0, 3);
    imem[3]  = enc_r(7'h20, 2, 1, 5, 4);
    imem[4]  = enc_r(7'h00, 2, 1, 5, 5);
    imem[5]  = enc_r(7'h00, 2, 1, 2, 6);
    imem[6]  = enc_r(7'h00, 2, 1, 3, 7);
    imem[7]  = enc_i(4, 2, 1, 8, 7'h13);
    imem[8]  = enc_i(32'hFF, 1, 4, 9, 7'h13);
    imem[9]  = enc_u(1, 10, 7'h17);
    imem[10] = enc_i(32'h11, 2, 0, 11, 7'h67);
    exp_rf = '{32'hFFFF_FFF0, 32'h3, 32'hFFFF_FFED, 32'hFFFF_FFFE, 32'h1FFF_FFFE,
               32'h1, 32'h0, 32'h30, 32'hFFFF_FF0F, 32'h1024, 32'h2C};
    do_reset();
    step(55);
    for (int r = 1; r <= 11; r++) check($sformatf("alu_x%0d", r), rf(r), exp_rf[r]);
    check("jalr_pc", {24'b0, pc}, 32'h14);

    clear_imem();
    imem[0] = enc_i(32'h55, 0, 0, 2, 7'h13);
    imem[1] = enc_s(32'h20, 2, 0, 2);
    exp_st.push_back('{mode: 2'b10, addr: 8'h20, data: 32'h55});
    do_reset();
    step(8);
    check("abort_in_mem", {29'b0, dut.state}, 32'd3);
    n_rst = 1'b1;
    step(1);
    check("abort_wr_en", {31'b0, wr_en}, 32'd0);
    check("abort_pc", {24'b0, pc}, 32'd0);
    check("abort_state", {29'b0, dut.state}, 32'd0);
    acc = 32'd0;
    for (int r = 0; r < 32; r++) acc = acc | rf(r);
    check("abort_rf_clear", acc, 32'd0);
    check("abort_sb_empty", exp_st.size(), 32'd0);
    #1 n_rst = 1'b0;

    clear_imem();
    imem[0] = 32'h0000_0F80;
    imem[1] = 32'h0000_0073;
    do_reset();
    step(10);
`ifdef RV32I_HALT_ON_ILLEGAL_EN
    check("illegal_pc", {24'b0, pc}, 32'd0);
    check("halt_state", {29'b0, dut.state}, 32'd5);
    step(20);
    check("halt_pc_frozen", {24'b0, pc}, 32'd0);
`else
    check("illegal_pc", {24'b0, pc}, 32'd8);
`endif
    check("illegal_no_wb", rf(31), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
